// File: rtl/unidade_muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
// Also holds the M-extension decode constants used by the core.
package unidade_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [2:0] funct3;
    logic       neg_res;
    logic       neg_rem;
  } op_t;

  function automatic logic signed_a(input logic [2:0] f);
    return f == F3_MULH || f == F3_MULHSU ||
           f == F3_DIV  || f == F3_REM;
  endfunction

  function automatic logic signed_b(input logic [2:0] f);
    return f == F3_MULH || f == F3_DIV ||
           f == F3_REM;
  endfunction

endpackage

// File: rtl/unidade_muldiv_if.sv
// Request/response bundle between the core and the muldiv unit.
// master = core side, slave = unit side.
interface unidade_muldiv_if
  import unidade_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start,
    output funct3,
    output rs1_data,
    output rs2_data,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  funct3,
    input  rs1_data,
    input  rs2_data,
    output busy,
    output done,
    output result
  );

endinterface

// File: rtl/unidade_muldiv_passo.sv
// One iteration of the muldiv datapath: shift-add multiply step
// (LSB first) or restoring-divide step (MSB first).
module passo_muldiv
  import unidade_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   resto,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   resto_nxt
);

  logic [XLEN:0]   soma;
  logic [XLEN:0]   parcial;
  logic [XLEN+1:0] dif;

  always_comb begin
    soma    = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, opb} : '0);
    parcial = {resto, acc[XLEN-1]};
    dif     = {1'b0, parcial} - {2'b00, opb};
    acc_nxt   = {soma, acc[XLEN-1:1]};
    resto_nxt = resto;
    if (is_div) begin
      // borrow out of the trial subtract means restore
      acc_nxt   = {acc[2*XLEN-1:XLEN],
                   acc[XLEN-2:0], ~dif[XLEN+1]};
      resto_nxt = dif[XLEN+1] ? parcial[XLEN-1:0]
                              : dif[XLEN-1:0];
    end
  end

endmodule

// File: rtl/unidade_muldiv.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// XLEN iterations on magnitudes, then a sign-fix cycle.
module unidade_muldiv
  import unidade_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input logic              clockCPU,
  input logic              reset,
  unidade_muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CALC, SIGN, DONE
  } estado_t;

  estado_t           estado;
  logic [CW-1:0]     contador;
  op_t               op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   resto;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   result_q;
  logic              busy_q;
  logic              done_q;

  logic              s1;
  logic              s2;
  logic              div0;
  logic              ovf;
  logic              fast;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   resto_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   sel;

  assign s1   = signed_a(bus.funct3) & bus.rs1_data[XLEN-1];
  assign s2   = signed_b(bus.funct3) & bus.rs2_data[XLEN-1];
  assign mag1 = s1 ? -bus.rs1_data : bus.rs1_data;
  assign mag2 = s2 ? -bus.rs2_data : bus.rs2_data;

  assign div0 = bus.funct3[2] & (bus.rs2_data == '0);
  assign ovf  = bus.funct3[2] & ~bus.funct3[0]
              & (bus.rs1_data == MIN)
              & (&bus.rs2_data);
  assign fast = div0 | ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU
  assign fast_res = div0
    ? (bus.funct3[1] ? bus.rs1_data : '1)
    : (bus.funct3[1] ? '0 : MIN);

  passo_muldiv #(.XLEN(XLEN)) u_passo (
    .is_div    (op.funct3[2]),
    .acc       (acc),
    .resto     (resto),
    .opb       (opb),
    .acc_nxt   (acc_nxt),
    .resto_nxt (resto_nxt)
  );

  assign prod = op.neg_res ? -acc : acc;
  assign quo  = op.neg_res ? -acc[XLEN-1:0]
                           : acc[XLEN-1:0];
  assign rem  = op.neg_rem ? -resto : resto;

  always_comb begin
    sel = '0;
    unique case (op.funct3)
      F3_MUL:    sel = prod[XLEN-1:0];
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  sel = prod[2*XLEN-1:XLEN];
      F3_DIV,
      F3_DIVU:   sel = quo;
      F3_REM,
      F3_REMU:   sel = rem;
      default:   sel = '0;
    endcase
  end

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      contador <= '0;
      op       <= '0;
      acc      <= '0;
      resto    <= '0;
      opb      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (estado)
        IDLE, DONE: begin
          done_q <= 1'b0;
          estado <= IDLE;
          if (bus.start) begin
            op <= '{funct3:  bus.funct3,
                    neg_res: s1 ^ s2,
                    neg_rem: s1};
            if (fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              estado   <= DONE;
            end else begin
              // divide: dividend in acc low, divisor in opb
              acc <= {{XLEN{1'b0}},
                      bus.funct3[2] ? mag1 : mag2};
              opb <= bus.funct3[2] ? mag2 : mag1;
              resto    <= '0;
              contador <= CW'(XLEN - 1);
              busy_q   <= 1'b1;
              estado   <= CALC;
            end
          end
        end
        CALC: begin
          acc      <= acc_nxt;
          resto    <= resto_nxt;
          contador <= contador - CW'(1);
          if (contador == '0) estado <= SIGN;
        end
        SIGN: begin
          result_q <= sel;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          estado   <= DONE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_unidade_muldiv.sv
// Bench for unidade_muldiv: directed cases plus random ops
// against a plain-arithmetic RV32M reference.
module tb_unidade_muldiv;

  localparam logic [31:0] MIN  = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clockCPU = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  unidade_muldiv_if #(.XLEN(32)) bus ();

  unidade_muldiv #(.XLEN(32)) dut (
    .clockCPU (clockCPU),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clockCPU = ~clockCPU;

  function automatic logic [31:0] modelo(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    r  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin
        p = sa * longint'({32'd0, b});
        return p[63:32];
      end
      3'd3: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MIN && b == ONES) return MIN;
        r = sa / sb;
        return r[31:0];
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == ONES) return 32'd0;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return ONES;
      2:       return MIN;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_done(inout int k, output logic busy_ok);
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && k < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clockCPU);
      k++;
    end
  endtask

  task automatic run(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input string       tag
  );
    int          k;
    logic        fast;
    logic        busy_ok;
    logic [31:0] exp;
    exp  = modelo(f, a, b);
    fast = f[2] && (b == 0 ||
           (!f[0] && a == MIN && b == ONES));
    @(negedge clockCPU);
    bus.funct3   = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.start    = 1'b1;
    @(negedge clockCPU);
    bus.start = 1'b0;
    k = 0;
    wait_done(k, busy_ok);
    chk({tag, "_lat"}, 32'(k), fast ? 32'd0 : 32'd33);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clockCPU);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    int          k;
    logic        busy_ok;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    repeat (2) @(negedge clockCPU);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    reset = 1'b0;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    run(3'd1, MIN, MIN, "mulh_min");
    run(3'd3, ONES, ONES, "mulhu_ones");
    run(3'd2, ONES, ONES, "mulhsu_ones");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run(3'd5, 32'd100, 32'd7, "divu_100_7");
    run(3'd7, 32'd100, 32'd7, "remu_100_7");
    run(3'd5, 32'd5, 32'd0, "divu_by0");
    run(3'd6, 32'd5, 32'd0, "rem_by0");
    run(3'd4, MIN, ONES, "div_ovf");
    run(3'd6, MIN, ONES, "rem_ovf");
    run(3'd0, 32'd0, 32'd12345, "mul_zero");
    run(3'd7, 32'd100, 32'd7, "remu_pre_rst");

    // asynchronous reset in the middle of a divide
    @(negedge clockCPU);
    bus.funct3   = 3'd4;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd7;
    bus.start    = 1'b1;
    @(negedge clockCPU);
    bus.start = 1'b0;
    repeat (10) @(negedge clockCPU);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    @(negedge clockCPU);
    reset = 1'b0;
    run(3'd0, 32'd3, 32'd4, "mul_after_rst");

    // start re-pulsed while calculating is ignored
    @(negedge clockCPU);
    bus.funct3   = 3'd5;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd7;
    bus.start    = 1'b1;
    @(negedge clockCPU);
    bus.start = 1'b0;
    repeat (4) @(negedge clockCPU);
    bus.funct3   = 3'd0;
    bus.rs1_data = 32'd5;
    bus.rs2_data = 32'd6;
    bus.start    = 1'b1;
    @(negedge clockCPU);
    bus.start = 1'b0;
    k = 5;
    wait_done(k, busy_ok);
    chk("repulse_lat", 32'(k), 32'd33);
    chk("repulse_res", bus.result, 32'd142);

    // start held through done: next op accepted without a bubble
    @(negedge clockCPU);
    bus.funct3   = 3'd3;
    bus.rs1_data = ONES;
    bus.rs2_data = ONES;
    bus.start    = 1'b1;
    @(negedge clockCPU);
    k = 0;
    wait_done(k, busy_ok);
    chk("b2b_first_lat", 32'(k), 32'd33);
    chk("b2b_first_res", bus.result, 32'hFFFF_FFFE);
    bus.funct3   = 3'd5;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    @(negedge clockCPU);
    bus.start = 1'b0;
    chk("b2b_no_bubble_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_no_bubble_done", {31'd0, bus.done}, 32'd0);
    chk("b2b_held", bus.result, 32'hFFFF_FFFE);
    k = 0;
    wait_done(k, busy_ok);
    chk("b2b_second_lat", 32'(k), 32'd33);
    chk("b2b_second_res", bus.result, 32'd14);

    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run(f, a, b, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_muldiv.md
Name: unidade_muldiv

Overview:
- Iterative RV32M multiply/divide unit, downstream of register-file read in the single-cycle core; its result feeds the writeback mux.
- The core holds PC and stalls while busy is high or done is still low for an M-extension instruction.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Handshake is start/busy/done, one operation at a time.

Parameters:
- XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
- clockCPU  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; returns the unit to IDLE.
- start  in  1  request; sampled on rising edge of clockCPU.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  XLEN  operand A (dividend / multiplicand); captured with start.
- rs2_data  in  XLEN  operand B (divisor / multiplier); captured with start.
- busy  out  1  high in CALC and SIGN.
- done  out  1  one-cycle pulse; result is valid while done is high and is held afterwards.
- result  out  XLEN  registered result.

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, SIGN, DONE. Edge 0 is the edge that samples start.
- Acceptance: start is accepted only in IDLE or DONE. start in CALC/SIGN is ignored; inputs are not re-captured.
- Edge 0, normal case:
  - capture funct3.
  - capture operand magnitudes: absolute value for signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both).
  - capture result-sign flags.
  - counter=XLEN-1; go to CALC.
- CALC, multiply: shift-add on a 2*XLEN accumulator, one multiplier bit per edge, LSB first.
- CALC, divide: restoring divide, one quotient bit per edge, MSB first. Remainder is XLEN+1 bits for the trial subtract.
- CALC exit: edges 1..XLEN perform XLEN iterations; the edge with counter==0 goes to SIGN.
- SIGN (edge XLEN+1):
  - apply two's-complement negation where the sign flag is set.
  - select the field: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - write result; go to DONE.
  - Sign rules: product sign = sA xor sB; quotient sign = sA xor sB; remainder sign = sign of dividend.
- DONE: done=1 for exactly one cycle (visible after edge XLEN+1); next edge goes to IDLE, or to CALC/DONE if start=1.
- Fast paths (decided at edge 0, go directly to DONE, done visible after edge 0, busy never asserted):
  - divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1_data.
  - signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- Multiply by zero takes the full latency; there is no fast path.
- result keeps its value from done until the next write (SIGN or a fast path); it is never cleared except by reset.
- Back-to-back: start held high in DONE is accepted at that edge; there is no idle bubble.
- Arithmetic is exact, with no overflow flag. MUL takes the low XLEN bits regardless of signedness.

Decomposition:
- Parametros.v (shared, guarded by PARAM): XLEN default; FUNCT3_MUL..FUNCT3_REMU constants; OPCODE_OP and FUNCT7_MULDIV (0000001) for decode in the core.
- State encoding stays local to the module.
- One natural sub-module, passo_muldiv: combinational single-iteration step (shift-add or trial-subtract/shift), instantiated once.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> after edge 33: done=1, result=0xFFFFFFEB. busy high from edge 0 to edge 32.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done after edge 0, result 0xFFFFFFFF, busy never high. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM same operands -> 0.
- Reset asserted at iteration 10 of a DIV -> busy=0, done=0, result=0 immediately (asynchronous). A new MUL 3x4 afterwards -> 12 with full latency.
- start re-pulsed during CALC with different operands -> ignored, original result delivered. start held in DONE -> second operation accepted with no bubble; its result replaces the first after its own latency.
